// File: rtl/csi_rx_lane_deskew.sv
// Lane deskew for MIPI CSI-2 D-PHY byte lanes: delays early lanes so every lane's
// sync byte leaves on the same cycle. Optional skew_error_o via `define LANE_SKEW_ERROR_EN.
module csi_rx_lane_deskew #(
   parameter int LANES    = 4,
   parameter int MAX_SKEW = 7
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [LANES-1:0]   bytes_valid_i,
   input  logic [8*LANES-1:0] byte_i,
   output logic               lane_valid_o,
   output logic [8*LANES-1:0] lane_byte_o
`ifdef LANE_SKEW_ERROR_EN
   ,
   output logic               skew_error_o
`endif
);

   localparam int CW    = (MAX_SKEW < 1) ? 1 : $clog2(MAX_SKEW + 1);
   localparam int DEPTH = 1 << CW;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_MEASURE = 3'd1;
   localparam logic [2:0] ST_ALIGNED = 3'd2;
   localparam logic [2:0] ST_DRAIN   = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;

   logic [2:0]       state;
   logic [CW-1:0]    cnt;
   logic [LANES-1:0] risen;
   logic [CW-1:0]    rise   [LANES];
   logic [CW-1:0]    offset [LANES];

   // hist_*[k][i] holds lane k's input from i cycles ago; index 0 is the live input.
   logic             hist_v [LANES][1:MAX_SKEW];
   logic [7:0]       hist_b [LANES][1:MAX_SKEW];

   logic             tap_v  [LANES][DEPTH];
   logic [7:0]       tap_b  [LANES][DEPTH];

   logic [CW-1:0]    cnt_cur;
   logic [CW-1:0]    rise_nxt [LANES];
   logic [LANES-1:0] risen_nxt;
   logic             all_risen;
   logic [CW-1:0]    max_rise;
   logic [CW-1:0]    offset_sel [LANES];
   logic [LANES-1:0] sel_v;
   logic [8*LANES-1:0] aligned_word;
   logic             all_v;
   logic             in_any;
   logic             learning;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it holding a value (latch).
      for (int k = 0; k < LANES; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            tap_v[k][i] = 1'b0;
            tap_b[k][i] = 8'h00;
         end
         tap_v[k][0] = bytes_valid_i[k];
         tap_b[k][0] = byte_i[8*k +: 8];
         for (int i = 1; i <= MAX_SKEW; i++) begin
            tap_v[k][i] = hist_v[k][i];
            tap_b[k][i] = hist_b[k][i];
         end
      end
   end

   assign in_any   = |bytes_valid_i;
   assign learning = (state == ST_MEASURE) || ((state == ST_IDLE) && in_any);
   assign cnt_cur  = (state == ST_IDLE) ? '0 : cnt;

   // During learning the offsets are derived from this cycle's rises so the
   // first aligned word can leave on the same edge the last lane arrives.
   always_comb begin
      max_rise  = '0;
      risen_nxt = risen | bytes_valid_i;
      for (int k = 0; k < LANES; k++) begin
         rise_nxt[k] = risen[k] ? rise[k] : cnt_cur;
         if (rise_nxt[k] > max_rise) max_rise = rise_nxt[k];
      end
      all_risen    = &risen_nxt;
      aligned_word = '0;
      for (int k = 0; k < LANES; k++) begin
         offset_sel[k]          = (state == ST_ALIGNED) ? offset[k] : (max_rise - rise_nxt[k]);
         sel_v[k]               = tap_v[k][offset_sel[k]];
         aligned_word[8*k +: 8] = tap_b[k][offset_sel[k]];
      end
      all_v = &sel_v;
   end

   // NOTE: the history is a shift register, not a RAM, so it is cheap to clear on reset and stale bytes never leak into a new burst.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < LANES; k++) begin
            for (int i = 1; i <= MAX_SKEW; i++) begin
               hist_v[k][i] <= 1'b0;
               hist_b[k][i] <= 8'h00;
            end
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            hist_v[k][1] <= bytes_valid_i[k];
            hist_b[k][1] <= byte_i[8*k +: 8];
            for (int i = 2; i <= MAX_SKEW; i++) begin
               hist_v[k][i] <= hist_v[k][i-1];
               hist_b[k][i] <= hist_b[k][i-1];
            end
         end
      end
   end

   // NOTE: state is written with non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         risen        <= '0;
         lane_valid_o <= 1'b0;
         lane_byte_o  <= '0;
         for (int k = 0; k < LANES; k++) begin
            rise[k]   <= '0;
            offset[k] <= '0;
         end
      end else begin
         lane_valid_o <= 1'b0;
         lane_byte_o  <= '0;
         case (state)
            ST_IDLE, ST_MEASURE: begin
               if (learning) begin
                  risen <= risen_nxt;
                  for (int k = 0; k < LANES; k++) rise[k] <= rise_nxt[k];
                  if (all_risen) begin
                     state        <= ST_ALIGNED;
                     lane_valid_o <= all_v;
                     lane_byte_o  <= all_v ? aligned_word : '0;
                     for (int k = 0; k < LANES; k++) offset[k] <= offset_sel[k];
                  end else if (cnt_cur == CW'(MAX_SKEW)) begin
                     state <= ST_ERROR;
                  end else begin
                     state <= ST_MEASURE;
                     cnt   <= cnt_cur + 1'b1;
                  end
               end
            end
            ST_ALIGNED: begin
               if (all_v) begin
                  lane_valid_o <= 1'b1;
                  lane_byte_o  <= aligned_word;
               end else begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN, ST_ERROR: begin
               // A new alignment may only start once every lane has gone quiet.
               if (!in_any) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  risen <= '0;
                  for (int k = 0; k < LANES; k++) begin
                     rise[k]   <= '0;
                     offset[k] <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LANE_SKEW_ERROR_EN
   logic err_pulse;

   // Fires on entry to ERROR, or when the aligned stream ends ragged.
   assign err_pulse = (learning && !all_risen && (cnt_cur == CW'(MAX_SKEW))) ||
                      ((state == ST_ALIGNED) && !all_v && (|sel_v));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) skew_error_o <= 1'b0;
      else            skew_error_o <= err_pulse;
   end
`endif

endmodule

// File: tb/tb_csi_rx_lane_deskew.sv
// Scoreboard bench for csi_rx_lane_deskew: per-burst lane stimulus, an alignment
// model filling an expected-word queue, and per-cycle comparison of the outputs.
module tb_csi_rx_lane_deskew;

   localparam int LANES    = 4;
   localparam int MAX_SKEW = 7;
   localparam int NC       = 40;
   localparam int TAIL     = MAX_SKEW + 2;

   logic               clk_i = 1'b0;
   logic               reset_n_i = 1'b0;
   logic [LANES-1:0]   bytes_valid_i = '0;
   logic [8*LANES-1:0] byte_i = '0;
   logic               lane_valid_o;
   logic [8*LANES-1:0] lane_byte_o;
`ifdef LANE_SKEW_ERROR_EN
   logic               skew_error_o;
`endif

   always #5 clk_i = ~clk_i;

   csi_rx_lane_deskew #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .bytes_valid_i (bytes_valid_i),
      .byte_i        (byte_i),
      .lane_valid_o  (lane_valid_o),
`ifdef LANE_SKEW_ERROR_EN
      .skew_error_o  (skew_error_o),
`endif
      .lane_byte_o   (lane_byte_o)
   );

   typedef struct {
      int                 cyc;
      logic [8*LANES-1:0] word;
   } exp_t;

   exp_t       sb[$];
   logic       stim_v [NC][LANES];
   logic [7:0] stim_b [NC][LANES];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         exp_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < LANES; k++) begin
            stim_v[c][k] = 1'b0;
            stim_b[c][k] = 8'h00;
         end
   endtask

   // Sync byte first, then 0x11,0x22,... (seq) or random payload.
   task automatic set_lane(input int k, input int start, input int len, input bit seq);
      for (int i = 0; i < len; i++) begin
         if (start + i < NC) begin
            stim_v[start+i][k] = 1'b1;
            if (i == 0)   stim_b[start+i][k] = 8'hB8;
            else if (seq) stim_b[start+i][k] = 8'(i * 17);
            else          stim_b[start+i][k] = 8'($urandom);
         end
      end
   endtask

   // Alignment model: lane k's j-th aligned byte is the one j cycles after its
   // first valid, emitted one cycle after the latest lane's first valid.
   task automatic build_expect();
      int   rise [LANES];
      int   mx = -1;
      int   mn = NC;
      bit   ok = 1'b1;
      logic all_ok, any_ok;
      exp_t e;
      exp_err = 0;
      for (int k = 0; k < LANES; k++) begin
         rise[k] = -1;
         for (int c = NC - 1; c >= 0; c--) if (stim_v[c][k]) rise[k] = c;
         if (rise[k] < 0) ok = 1'b0;
         else begin
            if (rise[k] > mx) mx = rise[k];
            if (rise[k] < mn) mn = rise[k];
         end
      end
      if (!ok || (mx - mn) > MAX_SKEW) begin
         exp_err = 1;
      end else begin
         for (int j = 0; j < NC; j++) begin
            all_ok = 1'b1;
            any_ok = 1'b0;
            e.word = '0;
            for (int k = 0; k < LANES; k++) begin
               if (rise[k] + j < NC) begin
                  all_ok = all_ok & stim_v[rise[k]+j][k];
                  any_ok = any_ok | stim_v[rise[k]+j][k];
                  e.word[8*k +: 8] = stim_b[rise[k]+j][k];
               end else begin
                  all_ok = 1'b0;
               end
            end
            if (!all_ok) begin
               exp_err = any_ok ? 1 : 0;
               break;
            end
            e.cyc = mx + 1 + j;
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_burst(input string name);
      exp_t e;
      int   errs = 0;
      build_expect();
      for (int c = 0; c < NC + TAIL; c++) begin
         @(posedge clk_i);
         #1;
         for (int k = 0; k < LANES; k++) begin
            bytes_valid_i[k]   = (c < NC) ? stim_v[c][k] : 1'b0;
            byte_i[8*k +: 8]   = (c < NC) ? stim_b[c][k] : 8'h00;
         end
         @(negedge clk_i);
         if (lane_valid_o) begin
            if (sb.size() == 0) begin
               check({name, " spurious_valid"}, 64'(lane_valid_o), 64'd0);
            end else begin
               e = sb.pop_front();
               check({name, " cycle"}, 64'(c), 64'(e.cyc));
               check({name, " word"}, 64'(lane_byte_o), 64'(e.word));
            end
         end else begin
            check({name, " idle_zero"}, 64'(lane_byte_o), 64'd0);
         end
`ifdef LANE_SKEW_ERROR_EN
         errs += int'(skew_error_o);
`endif
      end
      check({name, " words_left"}, 64'(sb.size()), 64'd0);
`ifdef LANE_SKEW_ERROR_EN
      check({name, " skew_err_pulses"}, 64'(errs), 64'(exp_err));
`endif
      sb.delete();
   endtask

   initial begin
      // Reset held: random traffic must not reach the outputs.
      for (int c = 0; c < 6; c++) begin
         @(posedge clk_i);
         #1;
         bytes_valid_i = LANES'($urandom);
         byte_i        = $urandom;
         @(negedge clk_i);
         check("reset valid", 64'(lane_valid_o), 64'd0);
         check("reset byte", 64'(lane_byte_o), 64'd0);
      end
      bytes_valid_i = '0;
      byte_i        = '0;
      @(negedge clk_i);
      reset_n_i = 1'b1;

      clear_stim();
      set_lane(1, 2, 10, 1'b1);
      set_lane(2, 6, 10, 1'b1);
      set_lane(3, 6, 10, 1'b1);
      set_lane(0, 7, 10, 1'b1);
      run_burst("skew45");

      clear_stim();
      set_lane(1, 2, 8, 1'b1);
      set_lane(2, 4, 8, 1'b1);
      set_lane(3, 4, 8, 1'b1);
      set_lane(0, 5, 8, 1'b1);
      run_burst("skew23");

      // Lane1 ends early, then re-rises while the others are still valid.
      clear_stim();
      set_lane(1, 2, 6, 1'b1);
      set_lane(2, 4, 10, 1'b1);
      set_lane(3, 4, 10, 1'b1);
      set_lane(0, 5, 10, 1'b1);
      set_lane(1, 9, 2, 1'b0);
      run_burst("ragged_end");

      clear_stim();
      set_lane(0, 2, 14, 1'b1);
      set_lane(1, 2, 14, 1'b1);
      set_lane(2, 2, 14, 1'b1);
      set_lane(3, 2 + MAX_SKEW + 1, 6, 1'b1);
      run_burst("skew_overflow");

      clear_stim();
      set_lane(0, 2, 10, 1'b1);
      set_lane(1, 2, 10, 1'b1);
      set_lane(2, 2, 10, 1'b1);
      set_lane(3, 2 + MAX_SKEW, 10, 1'b1);
      run_burst("skew_max");

      clear_stim();
      for (int k = 0; k < LANES; k++) set_lane(k, 2, 6, 1'b1);
      run_burst("zero_skew");

      for (int r = 0; r < 4; r++) begin
         clear_stim();
         for (int k = 0; k < LANES; k++)
            set_lane(k, 1 + int'($urandom_range(0, MAX_SKEW)), int'($urandom_range(9, 14)), 1'b0);
         run_burst($sformatf("random%0d", r));
      end

      // Async reset in the middle of an aligned burst clears outputs without a clock edge.
      @(posedge clk_i);
      #1;
      bytes_valid_i = '1;
      byte_i        = {LANES{8'hB8}};
      @(posedge clk_i);
      #1;
      byte_i = {LANES{8'h5A}};
      @(negedge clk_i);
      check("pre_reset valid", 64'(lane_valid_o), 64'd1);
      check("pre_reset byte", 64'(lane_byte_o), 64'({LANES{8'hB8}}));
      #1;
      reset_n_i = 1'b0;
      #1;
      check("async_reset valid", 64'(lane_valid_o), 64'd0);
      check("async_reset byte", 64'(lane_byte_o), 64'd0);
      bytes_valid_i = '0;
      byte_i        = '0;
      @(negedge clk_i);
      reset_n_i = 1'b1;

      clear_stim();
      for (int k = 0; k < LANES; k++) set_lane(k, 2 + k, 8, 1'b0);
      run_burst("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
